// File: rtl/stopwatch_ctrl_if.sv
// Slow-clock/button inputs and display outputs of the MM:SS stopwatch controller.
// The controller takes the slave side; whatever drives the buttons takes the master side.
interface stopwatch_ctrl_if;
    logic        clk_1Hz;
    logic        start_stop;
    logic        clear;
    logic [15:0] bcd;
    logic        running;
    logic        rollover;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output clk_1Hz, start_stop, clear,
        input  bcd, running, rollover, an, seg, dp
    );

    modport slave (
        input  clk_1Hz, start_stop, clear,
        output bcd, running, rollover, an, seg, dp
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: synchronised tick/button edges, IDLE/RUN/PAUSE control,
// BCD seconds/minutes counter and a registered four-digit multiplexed display driver.
module stopwatch_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_50MHz,
    input  logic            reset,
    stopwatch_ctrl_if.slave sw_bus
);

    localparam int NUM_IN = 3;
    localparam int IN_TICK = 0;
    localparam int IN_SS = 1;
    localparam int IN_CLR = 2;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers and registered rising-edge pulses
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0]                  raw_in;
    logic [NUM_IN-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NUM_IN-1:0]                  prev_q;
    logic [NUM_IN-1:0]                  pulse_q;
    logic                               tick;
    logic                               ss_p;
    logic                               clr_p;

    assign raw_in = {sw_bus.clear, sw_bus.start_stop, sw_bus.clk_1Hz};

    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // a blocking = here would collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
                prev_q[i]  <= sync_q[i][SYNC_STAGES-1];
                pulse_q[i] <= sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
            end
        end
    end

    assign tick  = pulse_q[IN_TICK];
    assign ss_p  = pulse_q[IN_SS];
    assign clr_p = pulse_q[IN_CLR];

    // ------------------------------------------------------------------
    // Control FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = S_IDLE;
        end else if (ss_p) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [15:0] bcd_q;
    logic [15:0] bcd_inc;
    logic [15:0] bcd_d;
    logic        count_en;
    logic        at_max;
    logic        running_q;
    logic        running_d;
    logic        rollover_q;
    logic        rollover_d;

    assign at_max = (bcd_q == 16'h5959);

    // Ticks count only while already in RUN, so the RUN->PAUSE cycle still counts
    // and the cycle that enters RUN does not.
    always_comb begin
        count_en   = (state_q == S_RUN) && tick && !clr_p;
        running_d  = (state_d == S_RUN);
        rollover_d = count_en && at_max;
        bcd_d      = bcd_q;
        if (clr_p) begin
            bcd_d = 16'h0000;
        end else if (count_en) begin
            bcd_d = bcd_inc;
        end
    end

    // Ripple BCD increment: each digit carries only when all lower digits wrap.
    always_comb begin
        bcd_inc = bcd_q;
        if (bcd_q[3:0] != 4'd9) begin
            bcd_inc[3:0] = bcd_q[3:0] + 4'd1;
        end else begin
            bcd_inc[3:0] = 4'd0;
            if (bcd_q[7:4] != 4'd5) begin
                bcd_inc[7:4] = bcd_q[7:4] + 4'd1;
            end else begin
                bcd_inc[7:4] = 4'd0;
                if (bcd_q[11:8] != 4'd9) begin
                    bcd_inc[11:8] = bcd_q[11:8] + 4'd1;
                end else begin
                    bcd_inc[11:8] = 4'd0;
                    if (bcd_q[15:12] != 4'd5) begin
                        bcd_inc[15:12] = bcd_q[15:12] + 4'd1;
                    end else begin
                        bcd_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            bcd_q      <= 16'h0000;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan: digit index and segment data come from next-state values
    // so an/seg/dp switch together on the same edge as the count.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       digit_q;
    logic [1:0]       digit_d;
    logic [3:0]       nibble_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    always_comb begin
        div_d   = div_q + 1'b1;
        digit_d = digit_q;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = digit_q + 2'd1;
        end
        nibble_d = bcd_d[{digit_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            digit_q <= 2'd0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
            dp_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            digit_q <= digit_d;
            an_q    <= ~(4'b0001 << digit_d);
            seg_q   <= seg_decode(nibble_d);
            dp_q    <= (digit_d != 2'd2);
        end
    end

    assign sw_bus.bcd      = bcd_q;
    assign sw_bus.running  = running_q;
    assign sw_bus.rollover = rollover_q;
    assign sw_bus.an       = an_q;
    assign sw_bus.seg      = seg_q;
    assign sw_bus.dp       = dp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized run,
// all compared against a seconds-based reference model.
module tb_stopwatch_ctrl;

    localparam int RD = 4;
    localparam int SS = 2;
    localparam int HW = SS + 2;

    logic clk_50MHz = 1'b0;
    logic reset = 1'b1;

    stopwatch_ctrl_if sw_bus ();

    stopwatch_ctrl #(
        .REFRESH_DIV(RD),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .reset    (reset),
        .sw_bus   (sw_bus)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int total = 0;
    int bad = 0;
    int shown = 0;
    bit armed = 1'b0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [15:0] to_bcd(input int secs);
        int m = secs / 60;
        int r = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    // Reference model: elapsed seconds plus a run/pause/idle mode. An input edge
    // sampled at edge n takes effect at edge n+SS+1.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_PAUSE} mstate_t;
    int          m_secs = 0;
    mstate_t     m_st = M_IDLE;
    bit          m_roll = 1'b0;
    logic [HW-1:0] h_tick = '0, h_ss = '0, h_clr = '0;
    logic        ev_t, ev_s, ev_c;

    assign ev_t = h_tick[SS] & ~h_tick[SS+1];
    assign ev_s = h_ss[SS] & ~h_ss[SS+1];
    assign ev_c = h_clr[SS] & ~h_clr[SS+1];

    always @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            h_tick <= '0;
            h_ss   <= '0;
            h_clr  <= '0;
            m_secs <= 0;
            m_st   <= M_IDLE;
            m_roll <= 1'b0;
        end else begin
            h_tick <= {h_tick[HW-2:0], sw_bus.clk_1Hz};
            h_ss   <= {h_ss[HW-2:0], sw_bus.start_stop};
            h_clr  <= {h_clr[HW-2:0], sw_bus.clear};
            m_roll <= 1'b0;
            if (ev_c) begin
                m_secs <= 0;
                m_st   <= M_IDLE;
            end else begin
                if (m_st == M_RUN && ev_t) begin
                    m_secs <= (m_secs + 1) % 3600;
                    m_roll <= (m_secs == 3599);
                end
                if (ev_s) m_st <= (m_st == M_RUN) ? M_PAUSE : M_RUN;
            end
        end
    end

    // Per-cycle comparison of count/state outputs against the model.
    always @(negedge clk_50MHz) begin
        if (armed && reset) begin
            total++;
            if (sw_bus.bcd !== to_bcd(m_secs) || sw_bus.running !== (m_st == M_RUN) ||
                sw_bus.rollover !== m_roll) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL monitor t=%0t bcd=%h want %h running=%b want %b rollover=%b want %b",
                             $time, sw_bus.bcd, to_bcd(m_secs), sw_bus.running, (m_st == M_RUN),
                             sw_bus.rollover, m_roll);
                end
            end
        end
    end

    // Per-cycle display scan check: order, dwell length and segment content.
    logic [3:0]  an_prev;
    int          run_len;
    bit          run_first;
    int          scan_idx;
    logic [15:0] scan_bcd;

    always @(negedge clk_50MHz) begin
        if (!armed || !reset) begin
            run_first = 1'b1;
            run_len   = 0;
            an_prev   = sw_bus.an;
        end else begin
            if (sw_bus.an !== an_prev) begin
                if (!run_first) begin
                    total++;
                    if (run_len != RD) begin
                        bad++;
                        if (shown < 20) begin
                            shown++;
                            $display("FAIL scan_len t=%0t held=%0d want %0d", $time, run_len, RD);
                        end
                    end
                end
                total++;
                if (sw_bus.an !== {an_prev[2:0], an_prev[3]}) begin
                    bad++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL scan_order t=%0t an=%b want %b", $time, sw_bus.an,
                                 {an_prev[2:0], an_prev[3]});
                    end
                end
                run_first = 1'b0;
                run_len   = 1;
                an_prev   = sw_bus.an;
            end else begin
                run_len++;
            end
            scan_idx = -1;
            for (int i = 0; i < 4; i++) if (sw_bus.an === ~(4'b0001 << i)) scan_idx = i;
            scan_bcd = to_bcd(m_secs);
            total++;
            if (scan_idx < 0 || sw_bus.seg !== pat[scan_bcd[scan_idx*4 +: 4]] ||
                sw_bus.dp !== (scan_idx != 2)) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL scan_out t=%0t an=%b seg=%b dp=%b bcd_want=%h", $time, sw_bus.an,
                             sw_bus.seg, sw_bus.dp, scan_bcd);
                end
            end
        end
    end

    // Raise the selected inputs on a falling edge, hold hi cycles, drop, wait lo cycles.
    task automatic drive(input bit t, input bit s, input bit c, input int hi, input int lo);
        @(negedge clk_50MHz);
        if (t) sw_bus.clk_1Hz = 1'b1;
        if (s) sw_bus.start_stop = 1'b1;
        if (c) sw_bus.clear = 1'b1;
        repeat (hi) @(negedge clk_50MHz);
        if (t) sw_bus.clk_1Hz = 1'b0;
        if (s) sw_bus.start_stop = 1'b0;
        if (c) sw_bus.clear = 1'b0;
        repeat (lo) @(negedge clk_50MHz);
    endtask

    task automatic test_reset();
        sw_bus.clk_1Hz = 1'b0;
        sw_bus.start_stop = 1'b0;
        sw_bus.clear = 1'b0;
        #3 reset = 1'b0;
        armed = 1'b1;
        #2;
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd got %h want 0000", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got %b want 0", sw_bus.running); end
        total++; if (sw_bus.rollover !== 1'b0) begin bad++; $display("FAIL reset_rollover got %b want 0", sw_bus.rollover); end
        total++; if (sw_bus.an !== 4'b1110) begin bad++; $display("FAIL reset_an got %b want 1110", sw_bus.an); end
        total++; if (sw_bus.seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg got %b want 1000000", sw_bus.seg); end
        total++; if (sw_bus.dp !== 1'b1) begin bad++; $display("FAIL reset_dp got %b want 1", sw_bus.dp); end
        repeat (3) @(negedge clk_50MHz);
        reset = 1'b1;
        repeat (4) @(negedge clk_50MHz);
    endtask

    task automatic test_basic_count();
        logic [15:0] old;
        drive(0, 1, 0, 3, 3);
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL start_running got %b want 1", sw_bus.running); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50MHz);
            sw_bus.clk_1Hz = 1'b1;
            old = sw_bus.bcd;
            repeat (3) @(posedge clk_50MHz);
            #1;
            total++; if (sw_bus.bcd !== old) begin bad++; $display("FAIL tick_early got %h want %h", sw_bus.bcd, old); end
            @(posedge clk_50MHz);
            #1;
            total++; if (sw_bus.bcd !== old + 16'd1) begin bad++; $display("FAIL tick_latency got %h want %h", sw_bus.bcd, old + 16'd1); end
            @(negedge clk_50MHz);
            sw_bus.clk_1Hz = 1'b0;
            repeat (3) @(negedge clk_50MHz);
        end
        total++; if (sw_bus.bcd !== 16'h0003) begin bad++; $display("FAIL basic_bcd got %h want 0003", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL basic_running got %b want 1", sw_bus.running); end
    endtask

    task automatic test_rollover();
        int rolls = 0;
        drive(0, 0, 1, 3, 3);
        drive(0, 1, 0, 3, 3);
        repeat (3599) drive(1, 0, 0, 2, 2);
        total++; if (sw_bus.bcd !== 16'h5959) begin bad++; $display("FAIL preload_bcd got %h want 5959", sw_bus.bcd); end
        @(negedge clk_50MHz);
        sw_bus.clk_1Hz = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50MHz);
            if (i == 3) sw_bus.clk_1Hz = 1'b0;
            if (sw_bus.rollover === 1'b1) rolls++;
        end
        total++; if (rolls != 1) begin bad++; $display("FAIL rollover_cycles got %0d want 1", rolls); end
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL rollover_bcd got %h want 0000", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL rollover_running got %b want 1", sw_bus.running); end
    endtask

    task automatic test_clear_priority();
        int rolls = 0;
        drive(0, 0, 1, 3, 3);
        drive(0, 1, 0, 3, 3);
        repeat (9) drive(1, 0, 0, 2, 2);
        total++; if (sw_bus.bcd !== 16'h0009) begin bad++; $display("FAIL pre_clear_bcd got %h want 0009", sw_bus.bcd); end
        @(negedge clk_50MHz);
        sw_bus.clk_1Hz = 1'b1;
        sw_bus.clear = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50MHz);
            if (i == 2) begin
                sw_bus.clk_1Hz = 1'b0;
                sw_bus.clear = 1'b0;
            end
            if (sw_bus.rollover === 1'b1) rolls++;
        end
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL clear_bcd got %h want 0000", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b0) begin bad++; $display("FAIL clear_running got %b want 0", sw_bus.running); end
        total++; if (rolls != 0) begin bad++; $display("FAIL clear_rollover got %0d want 0", rolls); end
        drive(1, 0, 0, 2, 4);
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL idle_tick got %h want 0000", sw_bus.bcd); end
    endtask

    task automatic test_pause();
        drive(0, 0, 1, 3, 3);
        drive(0, 1, 0, 3, 3);
        repeat (5) drive(1, 0, 0, 2, 2);
        total++; if (sw_bus.bcd !== 16'h0005) begin bad++; $display("FAIL run5_bcd got %h want 0005", sw_bus.bcd); end
        drive(0, 1, 0, 3, 3);
        total++; if (sw_bus.running !== 1'b0) begin bad++; $display("FAIL paused_running got %b want 0", sw_bus.running); end
        repeat (4) drive(1, 0, 0, 2, 2);
        total++; if (sw_bus.bcd !== 16'h0005) begin bad++; $display("FAIL paused_bcd got %h want 0005", sw_bus.bcd); end
        drive(0, 1, 0, 3, 3);
        drive(1, 0, 0, 2, 4);
        total++; if (sw_bus.bcd !== 16'h0006) begin bad++; $display("FAIL resume_bcd got %h want 0006", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL resume_running got %b want 1", sw_bus.running); end
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 0, 3, 3);
        total++; if (sw_bus.bcd !== 16'h0007) begin bad++; $display("FAIL run_to_pause_tick got %h want 0007", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b0) begin bad++; $display("FAIL run_to_pause_state got %b want 0", sw_bus.running); end
        drive(1, 1, 0, 3, 3);
        total++; if (sw_bus.bcd !== 16'h0007) begin bad++; $display("FAIL pause_to_run_tick got %h want 0007", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL pause_to_run_state got %b want 1", sw_bus.running); end
        drive(0, 0, 1, 3, 3);
        drive(1, 1, 0, 3, 3);
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL idle_to_run_tick got %h want 0000", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b1) begin bad++; $display("FAIL idle_to_run_state got %b want 1", sw_bus.running); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int         exp_dig [4] = '{4, 3, 2, 1};
        logic [3:0] last;
        bit         found = 1'b0;
        drive(0, 0, 1, 3, 3);
        drive(0, 1, 0, 3, 3);
        repeat (754) drive(1, 0, 0, 2, 2);
        drive(0, 1, 0, 3, 3);
        total++; if (sw_bus.bcd !== 16'h1234) begin bad++; $display("FAIL scan_preload got %h want 1234", sw_bus.bcd); end
        last = sw_bus.an;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk_50MHz);
            if (last === 4'b0111 && sw_bus.an === 4'b1110) found = 1'b1;
            last = sw_bus.an;
        end
        total++; if (!found) begin bad++; $display("FAIL scan_align got no 0111->1110 want one within 64 cycles"); end
        if (found) begin
            for (int d = 0; d < 4; d++) begin
                for (int k = 0; k < RD; k++) begin
                    if (d != 0 || k != 0) @(negedge clk_50MHz);
                    total++;
                    if (sw_bus.an !== exp_an[d] || sw_bus.seg !== pat[exp_dig[d]] || sw_bus.dp !== (d != 2)) begin
                        bad++;
                        $display("FAIL scan_1234 d=%0d k=%0d an=%b/%b seg=%b/%b dp=%b/%b", d, k, sw_bus.an,
                                 exp_an[d], sw_bus.seg, pat[exp_dig[d]], sw_bus.dp, (d != 2));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_50MHz);
        sw_bus.clk_1Hz = 1'b1;
        repeat (4) @(negedge clk_50MHz);
        @(posedge clk_50MHz);
        #5 reset = 1'b0;
        #1;
        total++; if (sw_bus.bcd !== 16'h0000) begin bad++; $display("FAIL midreset_bcd got %h want 0000", sw_bus.bcd); end
        total++; if (sw_bus.running !== 1'b0) begin bad++; $display("FAIL midreset_running got %b want 0", sw_bus.running); end
        total++; if (sw_bus.an !== 4'b1110 || sw_bus.seg !== 7'b1000000 || sw_bus.dp !== 1'b1) begin
            bad++;
            $display("FAIL midreset_display got an=%b seg=%b dp=%b want 1110 1000000 1", sw_bus.an, sw_bus.seg, sw_bus.dp);
        end
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        reset = 1'b1;
        repeat (20) @(negedge clk_50MHz);
        total++; if (sw_bus.bcd !== 16'h0000 || sw_bus.running !== 1'b0) begin
            bad++;
            $display("FAIL postreset_idle got bcd=%h running=%b want 0000 0", sw_bus.bcd, sw_bus.running);
        end
        drive(0, 1, 0, 3, 10);
        total++; if (sw_bus.bcd !== 16'h0000 || sw_bus.running !== 1'b1) begin
            bad++;
            $display("FAIL held_high_no_tick got bcd=%h running=%b want 0000 1", sw_bus.bcd, sw_bus.running);
        end
        sw_bus.clk_1Hz = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        drive(1, 0, 0, 3, 3);
        total++; if (sw_bus.bcd !== 16'h0001) begin bad++; $display("FAIL fresh_edge_tick got %h want 0001", sw_bus.bcd); end
    endtask

    task automatic test_random();
        int rst_at = $urandom_range(1000, 2000);
        drive(0, 0, 1, 3, 3);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_50MHz);
            if ($urandom_range(0, 2) == 0) sw_bus.clk_1Hz = ~sw_bus.clk_1Hz;
            if ($urandom_range(0, 15) == 0) sw_bus.start_stop = ~sw_bus.start_stop;
            if ($urandom_range(0, 79) == 0) sw_bus.clear = ~sw_bus.clear;
            if (i == rst_at) begin
                #3 reset = 1'b0;
                @(negedge clk_50MHz);
                @(negedge clk_50MHz);
                reset = 1'b1;
            end
        end
        sw_bus.clk_1Hz = 1'b0;
        sw_bus.start_stop = 1'b0;
        sw_bus.clear = 1'b0;
        repeat (10) @(negedge clk_50MHz);
        total++; if (sw_bus.bcd !== to_bcd(m_secs)) begin bad++; $display("FAIL random_final got %h want %h", sw_bus.bcd, to_bcd(m_secs)); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_rollover();
        test_clear_priority();
        test_pause();
        test_same_cycle();
        test_scan();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- REFRESH_DIV, 50000, clk_50MHz cycles each display digit is held active (1 kHz digit rate).
- SYNC_STAGES, 2, synchronizer flops on clk_1Hz, start_stop and clear (minimum 2).

REQ-002 Ports SHALL be as follows, one per line:
- clk_50MHz  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  slow clock from the divider stage, treated as data; each rising edge is one second.
- start_stop  in  1  pre-debounced button, active-high; its rising edge toggles run/pause.
- clear  in  1  pre-debounced button, active-high; its rising edge zeroes the count.
- bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- running  out  1  high while in the RUN state.
- rollover  out  1  one-cycle pulse when the count wraps from 59:59 to 00:00.
- an  out  4  digit enables, active-low; an[0] is sec_ones.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Function
REQ-003 clk_1Hz, start_stop and clear SHALL each pass through a SYNC_STAGES-flop synchronizer and then a one-flop rising-edge detector, giving a one-cycle internal pulse (tick, ss_p, clr_p).
- Latency: pulse is asserted during the cycle after the (SYNC_STAGES+1)th clk_50MHz edge at which the input is sampled high.
- A held-high input SHALL produce only one pulse.
REQ-004 The FSM SHALL have three states: IDLE, RUN and PAUSE.
- IDLE + ss_p -> RUN.
- RUN + ss_p -> PAUSE.
- PAUSE + ss_p -> RUN.
- clr_p in any state -> IDLE, and all four digits are set to 0 on the same edge.
REQ-005 clr_p SHALL take priority over ss_p and over tick when they occur in the same cycle.
REQ-006 The count SHALL increment by one second only on a tick cycle while in RUN. In IDLE and PAUSE, ticks are ignored and are not stored.
REQ-007 A tick arriving on the same cycle as the RUN->PAUSE transition SHALL be applied. A tick on the PAUSE->RUN or IDLE->RUN cycle SHALL NOT be applied.
REQ-008 Digit ranges: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5. Each digit carries into the next digit as in ordinary BCD counting.
REQ-009 At 59:59, a tick SHALL produce 00:00 and assert rollover for exactly that one cycle. The state SHALL remain RUN.
REQ-010 bcd and running SHALL be registered and SHALL update on the same edge as the count or state change.
REQ-011 The scan counter SHALL run freely in every state.
- Each digit is held for exactly REFRESH_DIV cycles, in the order 0,1,2,3,0.
- For the active digit, an has exactly one bit low.
REQ-012 seg SHALL show the BCD value of the active digit.
- Active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-013 dp SHALL be 0 only while digit 2 is active (MM.SS separator), and 1 otherwise.
REQ-014 an, seg and dp SHALL be registered and change together. No partial-digit glitches are allowed.

Reset
REQ-015 Asserting reset (low) SHALL immediately set the following, regardless of the clock:
- state IDLE, bcd=16'h0000, running=0, rollover=0;
- scan counter 0, an=4'b1110, seg=7'b1000000, dp=1;
- all synchronizer and edge-detector flops cleared to 0.
REQ-016 Reset asserted mid-count or mid-scan SHALL discard all state. After release, the first pulse SHALL require a fresh rising edge on the input, seen after the flops have cleared.
REQ-017 An input that is already high when reset is released SHALL produce an edge pulse. This is accepted behaviour.

Verification
REQ-018 Reset release, then a start_stop edge, then 3 clk_1Hz edges -> running=1, bcd=16'h0003; each increment occurs 3 cycles after the clk_1Hz rise is sampled.
REQ-019 Preload by 3599 ticks in RUN, then one more tick -> bcd=16'h0000, rollover high for 1 cycle, running stays 1.
REQ-020 Count at 00:09 in RUN, then clear and tick in the same cycle -> bcd=16'h0000, state IDLE, running=0, no rollover.
REQ-021 RUN at 00:05, start_stop edge, 4 ticks, start_stop edge, 1 tick -> bcd=16'h0006, running=1.
REQ-022 With bcd=16'h1234 and REFRESH_DIV=4 -> an cycles through 1110/1101/1011/0111, each for 4 cycles; seg shows 4,3,2,1 in that order; dp=0 only for an=1011.
REQ-023 Reset pulsed low at 12:34 while clk_1Hz stays high -> all outputs at reset values; no increment until start_stop is pressed and clk_1Hz has gone low and risen again.
